// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit                                                        |
// | Resolves branches/jumps from ALU flags, owns the fetch PC, and generates   |
// | flush pulses plus a pending-redirect buffer across fetch stalls.           |
// | Optional counters: define BRANCH_RESOLVE_STATS_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [3:0]  inst_id,
  input  logic [15:0] branch_pc,
  input  logic [15:0] offset,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_pos,
  input  logic        stall,
  output logic [15:0] pc,
  output logic        pc_valid,
  output logic        taken,
  output logic        flush,
  output logic        flag_zero,
  output logic        flag_pos,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_taken
);

  localparam logic [3:0] c_op_beq = 4'b0001;
  localparam logic [3:0] c_op_bne = 4'b0010;
  localparam logic [3:0] c_op_bgt = 4'b0011;
  localparam logic [3:0] c_op_jr  = 4'b0101;
  localparam logic [2:0] c_flush_load = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_pc_valid;
  logic        r_taken;
  logic        r_flush;
  logic        r_flag_zero;
  logic        r_flag_pos;
  logic [2:0]  r_flush_cnt;
  logic        r_pend_valid;
  logic [15:0] r_pend_target;

  logic        w_is_branch;
  logic        w_cond;
  logic        w_redirect;
  logic [15:0] w_target;
  logic        w_apply;
  logic [15:0] w_apply_target;

  // Decode is only meaningful in RUN; BOOT and FLUSH ignore the issue port.
  always_comb begin
    w_is_branch = 1'b0;
    w_cond      = 1'b0;
    w_target    = branch_pc + offset;
    case (inst_id)
      c_op_beq: begin w_is_branch = 1'b1; w_cond = alu_zero; end
      c_op_bne: begin w_is_branch = 1'b1; w_cond = !alu_zero; end
      c_op_bgt: begin w_is_branch = 1'b1; w_cond = alu_pos && !alu_zero; end
      c_op_jr:  begin w_is_branch = 1'b1; w_cond = 1'b1; w_target = alu_out; end
      default:  begin w_is_branch = 1'b0; w_cond = 1'b0; end
    endcase
  end

  logic w_decode;
  assign w_decode   = issue_valid && (r_state == ST_RUN) && w_is_branch;
  assign w_redirect = w_decode && w_cond;
  // The branch issued this cycle is younger than anything already pending.
  assign w_apply        = (r_state == ST_RUN) && !stall && (w_redirect || r_pend_valid);
  assign w_apply_target = w_redirect ? w_target : r_pend_target;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_pc_valid    <= 1'b0;
      r_taken       <= 1'b0;
      r_flush       <= 1'b0;
      r_flag_zero   <= 1'b0;
      r_flag_pos    <= 1'b0;
      r_flush_cnt   <= 3'd0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 16'h0000;
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        ST_BOOT: begin
          r_pc_valid <= 1'b1;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (issue_valid) begin
            r_flag_zero <= alu_zero;
            r_flag_pos  <= alu_pos;
          end
          if (w_apply) begin
            r_pc         <= w_apply_target;
            r_taken      <= 1'b1;
            r_flush      <= 1'b1;
            r_pc_valid   <= 1'b0;
            r_flush_cnt  <= c_flush_load;
            r_pend_valid <= 1'b0;
            r_state      <= ST_FLUSH;
          end else if (stall) begin
            if (w_redirect) begin
              r_pend_valid  <= 1'b1;
              r_pend_target <= w_target;
            end
          end else begin
            r_pc <= r_pc + PC_STEP;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 3'd0) begin
            r_flush    <= 1'b0;
            r_pc_valid <= 1'b1;
            r_state    <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_BOOT;
        end
      endcase
    end
  end

  assign pc        = r_pc;
  assign pc_valid  = r_pc_valid;
  assign taken     = r_taken;
  assign flush     = r_flush;
  assign flag_zero = r_flag_zero;
  assign flag_pos  = r_flag_pos;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_taken;

  // Saturating counters; stat_taken counts redirects applied, including deferred ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stat_branches <= 16'h0000;
      r_stat_taken    <= 16'h0000;
    end else begin
      if (w_decode && (r_stat_branches != 16'hFFFF)) begin
        r_stat_branches <= r_stat_branches + 16'd1;
      end
      if (w_apply && (r_stat_taken != 16'hFFFF)) begin
        r_stat_taken <= r_stat_taken + 16'd1;
      end
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`else
  assign stat_branches = 16'h0000;
  assign stat_taken    = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// Testbench for branch_resolve_unit: vector table driven through a scoreboard queue,
// plus hand-written reset-during-flush and reset-with-pending sequences.
module tb_branch_resolve_unit;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  inst_id;
  logic [15:0] branch_pc;
  logic [15:0] offset;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        alu_pos;
  logic        stall;
  logic [15:0] pc;
  logic        pc_valid;
  logic        taken;
  logic        flush;
  logic        flag_zero;
  logic        flag_pos;
  logic [15:0] stat_branches;
  logic [15:0] stat_taken;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(
    .RESET_PC(16'h0000),
    .PC_STEP(16'd2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .issue_valid(issue_valid),
    .inst_id(inst_id),
    .branch_pc(branch_pc),
    .offset(offset),
    .alu_out(alu_out),
    .alu_zero(alu_zero),
    .alu_pos(alu_pos),
    .stall(stall),
    .pc(pc),
    .pc_valid(pc_valid),
    .taken(taken),
    .flush(flush),
    .flag_zero(flag_zero),
    .flag_pos(flag_pos),
    .stat_branches(stat_branches),
    .stat_taken(stat_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [3:0]  op;
    logic [15:0] bpc;
    logic [15:0] off;
    logic [15:0] aout;
    logic        z;
    logic        p;
    logic        st;
    logic [15:0] e_pc;
    logic        e_pv;
    logic        e_tk;
    logic        e_fl;
    logic        e_fz;
    logic        e_fp;
    logic [15:0] e_sb;
    logic [15:0] e_st;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   vec_idx = 0;

  function automatic vec_t mk(input logic iv, input logic [3:0] op,
                              input logic [15:0] bpc, input logic [15:0] off,
                              input logic [15:0] aout, input logic z, input logic p,
                              input logic st, input logic [15:0] epc, input logic epv,
                              input logic etk, input logic efl, input logic efz,
                              input logic efp, input logic [15:0] esb,
                              input logic [15:0] est);
    vec_t v;
    v.iv = iv; v.op = op; v.bpc = bpc; v.off = off; v.aout = aout;
    v.z = z; v.p = p; v.st = st;
    v.e_pc = epc; v.e_pv = epv; v.e_tk = etk; v.e_fl = efl;
    v.e_fz = efz; v.e_fp = efp; v.e_sb = esb; v.e_st = est;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, got, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef BRANCH_RESOLVE_STATS_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  // Drive one cycle of stimulus (caller is away from the rising edge), check after it.
  task automatic apply(input vec_t v);
    vec_t e;
    issue_valid = v.iv; inst_id = v.op; branch_pc = v.bpc; offset = v.off;
    alu_out = v.aout; alu_zero = v.z; alu_pos = v.p; stall = v.st;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk("pc", vec_idx, pc, e.e_pc);
    chk("pc_valid", vec_idx, 16'(pc_valid), 16'(e.e_pv));
    chk("taken", vec_idx, 16'(taken), 16'(e.e_tk));
    chk("flush", vec_idx, 16'(flush), 16'(e.e_fl));
    chk("flag_zero", vec_idx, 16'(flag_zero), 16'(e.e_fz));
    chk("flag_pos", vec_idx, 16'(flag_pos), 16'(e.e_fp));
    chk("stat_branches", vec_idx, stat_branches, stat_exp(e.e_sb));
    chk("stat_taken", vec_idx, stat_taken, stat_exp(e.e_st));
    vec_idx++;
    @(negedge clock);
  endtask

  task automatic check_reset(input int tag);
    chk("rst_pc", tag, pc, 16'h0000);
    chk("rst_pc_valid", tag, 16'(pc_valid), 16'h0000);
    chk("rst_taken", tag, 16'(taken), 16'h0000);
    chk("rst_flush", tag, 16'(flush), 16'h0000);
    chk("rst_flag_zero", tag, 16'(flag_zero), 16'h0000);
    chk("rst_flag_pos", tag, 16'(flag_pos), 16'h0000);
    chk("rst_stat_branches", tag, stat_branches, 16'h0000);
    chk("rst_stat_taken", tag, stat_taken, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // iv op bpc off aout z p st | pc pv tk fl fz fp sb st
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0000,1,0,0,0,0, 16'd0,16'd0));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0002,1,0,0,0,0, 16'd0,16'd0));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0004,1,0,0,0,0, 16'd0,16'd0));
    vecs.push_back(mk(1,4'd1,16'h0010,16'h0020,16'h0000,1,0,0, 16'h0030,0,1,1,1,0, 16'd1,16'd1));
    vecs.push_back(mk(1,4'd2,16'h0040,16'h0100,16'h0000,0,1,0, 16'h0030,0,0,1,1,0, 16'd1,16'd1));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0030,1,0,0,1,0, 16'd1,16'd1));
    vecs.push_back(mk(1,4'd0,16'h0000,16'h0000,16'h0000,0,1,0, 16'h0032,1,0,0,0,1, 16'd1,16'd1));
    vecs.push_back(mk(1,4'd2,16'h0050,16'h0008,16'h0000,1,0,0, 16'h0034,1,0,0,1,0, 16'd2,16'd1));
    vecs.push_back(mk(1,4'd5,16'h0034,16'h0000,16'hFFFE,0,1,0, 16'hFFFE,0,1,1,0,1, 16'd3,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'hFFFE,0,0,1,0,1, 16'd3,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'hFFFE,1,0,0,0,1, 16'd3,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0000,1,0,0,0,1, 16'd3,16'd2));
    vecs.push_back(mk(1,4'd3,16'h00F0,16'h0010,16'h0000,0,1,1, 16'h0000,1,0,0,0,1, 16'd4,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,1, 16'h0000,1,0,0,0,1, 16'd4,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,1, 16'h0000,1,0,0,0,1, 16'd4,16'd2));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0100,0,1,1,0,1, 16'd4,16'd3));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0100,0,0,1,0,1, 16'd4,16'd3));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0100,1,0,0,0,1, 16'd4,16'd3));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0102,1,0,0,0,1, 16'd4,16'd3));
    vecs.push_back(mk(1,4'd1,16'h0200,16'h0010,16'h0000,1,0,1, 16'h0102,1,0,0,1,0, 16'd5,16'd3));
    vecs.push_back(mk(1,4'd2,16'h0300,16'hFFF0,16'h0000,0,0,1, 16'h0102,1,0,0,0,0, 16'd6,16'd3));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h02F0,0,1,1,0,0, 16'd6,16'd4));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h02F0,0,0,1,0,0, 16'd6,16'd4));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h02F0,1,0,0,0,0, 16'd6,16'd4));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h02F2,1,0,0,0,0, 16'd6,16'd4));
    vecs.push_back(mk(1,4'd3,16'h1000,16'h0010,16'h0000,1,1,0, 16'h02F4,1,0,0,1,1, 16'd7,16'd4));
    vecs.push_back(mk(1,4'd1,16'hFFF0,16'h0020,16'h0000,1,0,0, 16'h0010,0,1,1,1,0, 16'd8,16'd5));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0010,0,0,1,1,0, 16'd8,16'd5));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0010,1,0,0,1,0, 16'd8,16'd5));
    vecs.push_back(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0012,1,0,0,1,0, 16'd8,16'd5));
    vecs.push_back(mk(1,4'd5,16'h0000,16'h0000,16'h1234,0,0,0, 16'h1234,0,1,1,0,0, 16'd9,16'd6));

    reset = 1'b1; issue_valid = 1'b0; inst_id = 4'd0; branch_pc = 16'h0000;
    offset = 16'h0000; alu_out = 16'h0000; alu_zero = 1'b0; alu_pos = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clock);
    check_reset(0);
    reset = 1'b0;
    #1;
    chk("boot_pc_valid", 0, 16'(pc_valid), 16'h0000);

    foreach (vecs[i]) apply(vecs[i]);

    // Last vector left the unit in FLUSH after a JR; reset must discard it at once.
    #1 reset = 1'b1;
    #1 check_reset(1);
    @(negedge clock);
    reset = 1'b0;
    apply(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0000,1,0,0,0,0, 16'd0,16'd0));
    // Park a taken BEQ in the pending buffer, then reset: the target must be lost.
    apply(mk(1,4'd1,16'h0010,16'h0020,16'h0000,1,0,1, 16'h0000,1,0,0,1,0, 16'd1,16'd0));
    #1 reset = 1'b1;
    #1 check_reset(2);
    @(negedge clock);
    reset = 1'b0;
    apply(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0000,1,0,0,0,0, 16'd0,16'd0));
    apply(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0002,1,0,0,0,0, 16'd0,16'd0));
    apply(mk(0,4'd0,16'h0000,16'h0000,16'h0000,0,0,0, 16'h0004,1,0,0,0,0, 16'd0,16'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU result interface.
- Takes the ALU result and flags (out, zero, pos) for the issued instruction, decides branches and jumps, and owns the 16-bit program counter that drives fetch.
- Sits between the ALU and instruction fetch. Registers the flag state and the redirect, and generates flush pulses and a pending-redirect buffer for stall cycles.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, sequential PC increment (byte-addressed 16-bit words).
- FLUSH_CYCLES, 2, number of cycles flush is held after a redirect (legal range 1..7).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  an instruction is presented this cycle.
- inst_id  in  4  opcode of the issued instruction.
- branch_pc  in  16  PC of the issued instruction.
- offset  in  16  signed PC-relative branch offset.
- alu_out  in  16  ALU result for the issued instruction.
- alu_zero  in  1  ALU zero flag.
- alu_pos  in  1  ALU positive flag.
- stall  in  1  fetch stall; PC must hold.
- pc  out  16  fetch address.
- pc_valid  out  1  pc is a valid fetch address.
- taken  out  1  one-cycle pulse when a redirect is applied to pc.
- flush  out  1  squash younger instructions.
- flag_zero  out  1  registered zero flag of the last valid issue.
- flag_pos  out  1  registered positive flag of the last valid issue.
- stat_branches  out  16  branches resolved (optional feature).
- stat_taken  out  16  redirects taken (optional feature).

Behaviour:
- Reset values (asynchronous, while reset=1):
  - pc=RESET_PC; pc_valid=0; taken=0; flush=0.
  - flag_zero=0; flag_pos=0; pending buffer cleared; stats=0.
  - State goes to BOOT.
- Opcode decode (evaluated only when issue_valid=1):
  - 0001 BEQ: taken if alu_zero.
  - 0010 BNE: taken if !alu_zero.
  - 0011 BGT: taken if alu_pos && !alu_zero.
  - Target for BEQ/BNE/BGT = branch_pc + offset, modulo 2^16 (wrap-around, no trap).
  - 0101 JR: always taken, target = alu_out.
  - All other opcodes: non-branch.
  - flag_zero/flag_pos load alu_zero/alu_pos on every valid issue, branch or not.
- State BOOT: the first edge after reset deasserts sets pc_valid=1 and moves to RUN. pc stays RESET_PC on that edge.
- State RUN:
  - stall=0 and no redirect: pc <= pc + PC_STEP (wraps).
  - stall=1: pc holds.
- Redirect with stall=0:
  - Edge N: pc <= target, taken=1 and flush=1 for cycle N+1, pc_valid=0, enter FLUSH.
  - The flush counter loads FLUSH_CYCLES-1.
- Redirect with stall=1:
  - Target is latched into the pending buffer; pc holds.
  - The redirect is applied on the first edge where stall=0, with the same timing as above.
  - A second taken branch while pending is occupied replaces the pending target (youngest wins).
- State FLUSH:
  - flush=1 and pc_valid=0; issue_valid is ignored (no flag update, no decode).
  - pc holds.
  - The counter decrements each edge. At zero: flush=0, pc_valid=1, return to RUN.
  - The next edge resumes increment from the target.
- taken is a single-cycle pulse regardless of FLUSH_CYCLES.
- Reset mid-FLUSH or with a pending redirect: everything is discarded and the unit returns to BOOT.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined:
  - stat_branches increments on each decoded branch/jump in RUN.
  - stat_taken increments when a redirect is applied to pc.
  - Both are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release -> pc=0x0000 with pc_valid=0 for one cycle, then pc_valid=1, then 0x0002, 0x0004 on successive edges.
- BEQ with branch_pc=0x0010, offset=0x0020, alu_zero=1 -> pc=0x0030, one-cycle taken, flush high 2 cycles, pc_valid low 2 cycles, then 0x0032.
- BNE with alu_zero=1 -> not taken; pc keeps incrementing; flag_zero=1 next cycle.
- JR with alu_out=0xFFFE, then run -> pc=0xFFFE, after flush pc wraps to 0x0000.
- BGT taken (alu_pos=1, alu_zero=0, target 0x0100) while stall=1 for 3 cycles -> pc holds, redirect to 0x0100 on the first unstalled edge.
- Reset asserted mid-FLUSH -> immediate pc=RESET_PC, flush=0, taken=0; with BRANCH_RESOLVE_STATS_EN defined, stats read 0.
